// File: rtl/onchip_ram.sv
// NoC RAM endpoint: packed read/write requests in, {data, src} read replies out.
// Ports: clk, rst (async active-low), i_packed_in/i_valid_in/i_ready_out,
//        o_packed_out/o_valid_out/o_ready_in.
module onchip_ram #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 7,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  localparam int PACKED_IN   = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
  localparam int PACKED_OUT  = WIDTH + N_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PACKED_IN-1:0]  i_packed_in,
  input  logic                  i_valid_in,
  output logic                  i_ready_out,
  output logic [PACKED_OUT-1:0] o_packed_out,
  output logic                  o_valid_out,
  input  logic                  o_ready_in
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]        mem [DEPTH];

  logic [WIDTH-1:0]        req_data;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_we;
  logic                    req_re;
  logic [N_ADDR_WIDTH-1:0] req_src;

  logic                    acc;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    pop;
  logic [PACKED_OUT-1:0]   rd_pkt;

  logic                    or_valid;
  logic [PACKED_OUT-1:0]   or_data;
  logic                    sb_valid;
  logic [PACKED_OUT-1:0]   sb_data;

  assign {req_data, req_addr, req_we, req_re, req_src} = i_packed_in;

  assign acc    = i_valid_in & ~sb_valid;
  assign wr_acc = acc & req_we;
  assign rd_acc = acc & req_re;
  assign pop    = or_valid & o_ready_in;

  // Sampled before the write lands, so a combined
  // read+write returns the old word.
  assign rd_pkt = {mem[req_addr], req_src};

  // Storage is deliberately outside reset so contents
  // survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[req_addr] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      sb_valid <= 1'b0;
      sb_data  <= '0;
    end else begin
      if (sb_valid) begin
        // No reads are accepted while SB is full.
        if (pop) begin
          or_data  <= sb_data;
          sb_valid <= 1'b0;
        end
      end else if (rd_acc) begin
        if (or_valid && !pop) begin
          sb_data  <= rd_pkt;
          sb_valid <= 1'b1;
        end else begin
          or_data  <= rd_pkt;
          or_valid <= 1'b1;
        end
      end else if (pop) begin
        or_valid <= 1'b0;
      end
    end
  end

  assign i_ready_out  = ~sb_valid;
  assign o_valid_out  = or_valid;
  assign o_packed_out = or_data;

endmodule

// File: tb/tb_onchip_ram.sv
// Directed bench for onchip_ram: reset, fill, streaming reads,
// skid-buffer backpressure, read-before-write, reset retention.
module tb_onchip_ram;

  logic        clk;
  logic        rst;
  logic [20:0] i_packed_in;
  logic        i_valid_in;
  logic        i_ready_out;
  logic [11:0] o_packed_out;
  logic        o_valid_out;
  logic        o_ready_in;

  int n_run;
  int n_fail;

  onchip_ram dut (
    .clk         (clk),
    .rst         (rst),
    .i_packed_in (i_packed_in),
    .i_valid_in  (i_valid_in),
    .i_ready_out (i_ready_out),
    .o_packed_out(o_packed_out),
    .o_valid_out (o_valid_out),
    .o_ready_in  (o_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [6:0] addr;
    logic       we;
    logic       re;
    logic [3:0] src;
    logic       ordy;
    logic       e_vld;
    logic [7:0] e_data;
    logic [3:0] e_src;
    logic       e_rdy;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm,
                     input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic vld,
                       input logic [7:0] d,
                       input logic [6:0] a,
                       input logic we, input logic re,
                       input logic [3:0] s,
                       input logic ordy);
    i_valid_in  = vld;
    i_packed_in = {d, a, we, re, s};
    o_ready_in  = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic vld,
                              input logic [7:0] d,
                              input logic [6:0] a,
                              input logic we, input logic re,
                              input logic [3:0] s,
                              input logic ordy,
                              input logic ev,
                              input logic [7:0] ed,
                              input logic [3:0] es,
                              input logic er);
    vec_t v;
    v.vld = vld; v.data = d; v.addr = a;
    v.we = we; v.re = re; v.src = s;
    v.ordy = ordy; v.e_vld = ev;
    v.e_data = ed; v.e_src = es; v.e_rdy = er;
    return v;
  endfunction

  initial begin
    n_run  = 0;
    n_fail = 0;

    // backpressure: OR holds {127,0}, SB gets {6,4}
    vecs[0]  = mk(1, 8'h00, 7'd6, 0, 1, 4'd4, 0,
                  1, 8'd127, 4'd0, 0);
    // write while not ready must be dropped
    vecs[1]  = mk(1, 8'h55, 7'd6, 1, 0, 4'd0, 0,
                  1, 8'd127, 4'd0, 0);
    vecs[2]  = mk(0, 8'h00, 7'd0, 0, 0, 4'd0, 1,
                  1, 8'd6, 4'd4, 1);
    vecs[3]  = mk(0, 8'h00, 7'd0, 0, 0, 4'd0, 1,
                  0, 8'd6, 4'd4, 1);
    // read+write same address: old value back
    vecs[4]  = mk(1, 8'hAA, 7'd3, 1, 1, 4'd9, 1,
                  1, 8'd3, 4'd9, 1);
    vecs[5]  = mk(1, 8'h00, 7'd3, 0, 1, 4'd2, 1,
                  1, 8'hAA, 4'd2, 1);
    vecs[6]  = mk(1, 8'h00, 7'd6, 0, 1, 4'd5, 1,
                  1, 8'd6, 4'd5, 1);
    vecs[7]  = mk(0, 8'h00, 7'd0, 0, 0, 4'd0, 1,
                  0, 8'd6, 4'd5, 1);
    // no-op request
    vecs[8]  = mk(1, 8'h77, 7'd1, 0, 0, 4'd0, 1,
                  0, 8'd6, 4'd5, 1);
    vecs[9]  = mk(1, 8'h33, 7'd0, 1, 0, 4'd0, 1,
                  0, 8'd6, 4'd5, 1);
    vecs[10] = mk(1, 8'h00, 7'd0, 0, 1, 4'hF, 0,
                  1, 8'h33, 4'hF, 1);
    vecs[11] = mk(1, 8'h00, 7'd1, 0, 1, 4'd1, 0,
                  1, 8'h33, 4'hF, 0);
    vecs[12] = mk(0, 8'h00, 7'd0, 0, 0, 4'd0, 1,
                  1, 8'd1, 4'd1, 1);
    // consume and refill OR on the same edge
    vecs[13] = mk(1, 8'h00, 7'd2, 0, 1, 4'd3, 1,
                  1, 8'd2, 4'd3, 1);
    // stall for reset test
    vecs[14] = mk(0, 8'h00, 7'd0, 0, 0, 4'd0, 0,
                  1, 8'd2, 4'd3, 1);

    // 1: reset
    rst = 1'b0;
    drive(0, 8'h00, 7'd0, 0, 0, 4'd0, 1);
    repeat (3) step();
    chk("rst_valid", int'(o_valid_out), 0);
    chk("rst_ready", int'(i_ready_out), 1);
    chk("rst_packed", int'(o_packed_out), 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", int'(o_valid_out), 0);
    end

    // 2: fill
    for (int i = 0; i < 128; i++) begin
      drive(1, 8'(i), 7'(i), 1, 0, 4'd0, 1);
      step();
      chk("wr_valid", int'(o_valid_out), 0);
      chk("wr_ready", int'(i_ready_out), 1);
    end

    // 3: streaming reads
    for (int i = 0; i < 128; i++) begin
      drive(1, 8'h00, 7'(i), 0, 1, 4'((127 - i) & 15), 1);
      step();
      chk("rd_valid", int'(o_valid_out), 1);
      chk("rd_data", int'(o_packed_out[11:4]), i);
      chk("rd_src", int'(o_packed_out[3:0]),
          (127 - i) & 15);
      chk("rd_ready", int'(i_ready_out), 1);
    end

    // 4, 5: vector table
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].vld, vecs[k].data, vecs[k].addr,
            vecs[k].we, vecs[k].re, vecs[k].src,
            vecs[k].ordy);
      step();
      chk($sformatf("v%0d_valid", k),
          int'(o_valid_out), int'(vecs[k].e_vld));
      chk($sformatf("v%0d_ready", k),
          int'(i_ready_out), int'(vecs[k].e_rdy));
      if (vecs[k].e_vld) begin
        chk($sformatf("v%0d_data", k),
            int'(o_packed_out[11:4]), int'(vecs[k].e_data));
        chk($sformatf("v%0d_src", k),
            int'(o_packed_out[3:0]), int'(vecs[k].e_src));
      end
    end

    // 6: async reset during stall
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", int'(o_valid_out), 0);
    chk("arst_ready", int'(i_ready_out), 1);
    chk("arst_packed", int'(o_packed_out), 0);
    drive(0, 8'h00, 7'd0, 0, 0, 4'd0, 1);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("post_rst_valid", int'(o_valid_out), 0);
    drive(1, 8'h00, 7'd10, 0, 1, 4'd7, 1);
    step();
    chk("ret_valid", int'(o_valid_out), 1);
    chk("ret_data", int'(o_packed_out[11:4]), 10);
    chk("ret_src", int'(o_packed_out[3:0]), 7);
    drive(0, 8'h00, 7'd0, 0, 0, 4'd0, 1);
    step();
    chk("end_valid", int'(o_valid_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
